// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline sequencing controller for the 5-stage core.
//
// Each cycle it decides whether every pipeline register advances, holds or
// takes a bubble:
//   * load-use hazard on the IF/ID instruction -> one-cycle stall + ID/EX bubble
//   * EX-resolved redirect                     -> squash IF/ID and ID/EX
//   * data memory busy                         -> freeze, watchdog on the wait
//   * watchdog expiry                          -> HALT until reset
// It also produces registered EX forwarding selects and saturating
// stall / flush performance counters.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   ifid_instr_i/valid_i      instruction being decoded
//   idex_rd_i/mem_read_i      destination / load flag of the ID/EX instruction
//   exmem_rd_i/reg_write_i    destination / write flag of the EX/MEM instruction
//   memwb_rd_i/reg_write_i    destination / write flag of the MEM/WB instruction
//   ex_redirect_i             taken branch/jump resolved in EX
//   dmem_req_i, dmem_ready_i  data memory handshake
//   *_en_o, *_flush_o         pipeline register enables / bubble inserts
//   fwd_a_o, fwd_b_o          EX operand source (00 RF, 01 EX/MEM, 10 MEM/WB)
//   stall_cnt_o, flush_cnt_o  saturating performance counters
//   mem_err_o                 watchdog expired, pipeline halted
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      ifid_instr_i,
  input  logic             ifid_valid_i,
  input  logic [4:0]       idex_rd_i,
  input  logic             idex_mem_read_i,
  input  logic [4:0]       exmem_rd_i,
  input  logic             exmem_reg_write_i,
  input  logic [4:0]       memwb_rd_i,
  input  logic             memwb_reg_write_i,
  input  logic             ex_redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_en_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             memwb_flush_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             mem_err_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_HALT     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wd_q, wd_d, wd_inc;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             mem_err_q;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       use_rs1, use_rs2, load_use, mem_wait, redirect_hit, stall_inc;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // EX/MEM wins over MEM/WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (exmem_reg_write_i && exmem_rd_i != 5'd0 && exmem_rd_i == rs) return 2'b01;
    if (memwb_reg_write_i && memwb_rd_i != 5'd0 && memwb_rd_i == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Only opcode and source register fields are decoded here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{ifid_instr_i[31:25], ifid_instr_i[14:7]};

  assign opcode   = ifid_instr_i[6:0];
  assign rs1      = ifid_instr_i[19:15];
  assign rs2      = ifid_instr_i[24:20];
  assign use_rs1  = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign use_rs2  = (opcode == OPC_OP || opcode == OPC_STORE || opcode == OPC_BRANCH);
  assign load_use = ifid_valid_i && idex_mem_read_i && (idex_rd_i != 5'd0) &&
                    ((use_rs1 && rs1 == idex_rd_i) || (use_rs2 && rs2 == idex_rd_i));
  assign mem_wait = dmem_req_i && !dmem_ready_i;
  assign wd_inc   = wd_q + TO_W'(1);

  always_comb begin
    pc_en_o       = 1'b0;
    ifid_en_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_en_o     = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_en_o    = 1'b0;
    memwb_flush_o = 1'b0;
    redirect_hit  = 1'b0;
    state_d       = state_q;
    case (state_q)
      S_HALT: state_d = S_HALT;
      default: begin
        if (mem_wait) begin
          // Freeze everything up to EX/MEM; MEM/WB gets a bubble.
          memwb_flush_o = 1'b1;
          state_d       = S_MEM_WAIT;
          if (state_q == S_MEM_WAIT && wd_inc == TO_W'(MEM_TIMEOUT)) state_d = S_HALT;
        end else if (ex_redirect_i) begin
          // Redirect outranks load-use: the stalled instruction is wrong-path anyway.
          pc_en_o      = 1'b1;
          ifid_en_o    = 1'b1;
          idex_en_o    = 1'b1;
          exmem_en_o   = 1'b1;
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
          redirect_hit = 1'b1;
          state_d      = S_RUN;
        end else if (load_use) begin
          idex_en_o    = 1'b1;
          exmem_en_o   = 1'b1;
          idex_flush_o = 1'b1;
          state_d      = S_RUN;
        end else begin
          pc_en_o    = 1'b1;
          ifid_en_o  = 1'b1;
          idex_en_o  = 1'b1;
          exmem_en_o = 1'b1;
          state_d    = S_RUN;
        end
      end
    endcase
  end

  always_comb begin
    if (state_q != S_MEM_WAIT || dmem_ready_i) wd_d = '0;
    else if (mem_wait)                         wd_d = wd_inc;
    else                                       wd_d = wd_q;

    if (idex_flush_o) begin
      rs1_d = 5'd0;
      rs2_d = 5'd0;
    end else if (idex_en_o) begin
      rs1_d = use_rs1 ? rs1 : 5'd0;
      rs2_d = use_rs2 ? rs2 : 5'd0;
    end else begin
      rs1_d = rs1_q;
      rs2_d = rs2_q;
    end
  end

  assign stall_inc = (state_q != S_HALT) && !pc_en_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_RUN;
      wd_q        <= '0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      mem_err_q <= (state_d == S_HALT);
      if (stall_inc)    stall_cnt_q <= sat_inc(stall_cnt_q);
      if (redirect_hit) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign fwd_a_o     = fwd_sel(rs1_q);
  assign fwd_b_o     = fwd_sel(rs2_q);
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign mem_err_o   = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- directed scenarios followed by randomized traffic, every
// cycle compared against a behavioural model of the sequencing rules.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CNT_W       = 6;
  localparam int MEM_TIMEOUT = 4;
  localparam int TO_W        = 8;
  localparam int CMAX        = (1 << CNT_W) - 1;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, OP = 7'h33,
                         OPIMM = 7'h13, LOAD = 7'h03, STORE = 7'h23,
                         BRANCH = 7'h63, JALR = 7'h67;

  logic             clk = 1'b0;
  logic             rst_ni;
  logic [31:0]      ifid_instr_i;
  logic             ifid_valid_i;
  logic [4:0]       idex_rd_i, exmem_rd_i, memwb_rd_i;
  logic             idex_mem_read_i, exmem_reg_write_i, memwb_reg_write_i;
  logic             ex_redirect_i, dmem_req_i, dmem_ready_i;
  logic             pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o;
  logic             exmem_en_o, memwb_flush_o, mem_err_o;
  logic [1:0]       fwd_a_o, fwd_b_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ifid_instr_i(ifid_instr_i), .ifid_valid_i(ifid_valid_i),
    .idex_rd_i(idex_rd_i), .idex_mem_read_i(idex_mem_read_i),
    .exmem_rd_i(exmem_rd_i), .exmem_reg_write_i(exmem_reg_write_i),
    .memwb_rd_i(memwb_rd_i), .memwb_reg_write_i(memwb_reg_write_i),
    .ex_redirect_i(ex_redirect_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
    .pc_en_o(pc_en_o), .ifid_en_o(ifid_en_o), .ifid_flush_o(ifid_flush_o),
    .idex_en_o(idex_en_o), .idex_flush_o(idex_flush_o), .exmem_en_o(exmem_en_o),
    .memwb_flush_o(memwb_flush_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .mem_err_o(mem_err_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  bit m_halt;
  int m_streak, m_rs1, m_rs2, m_stall, m_flush;
  bit e_pc, e_ifid, e_ifidf, e_idex, e_idexf, e_exmem, e_memwbf, e_redir;
  int e_fa, e_fb;
  bit nx_halt;
  int nx_streak, nx_rs1, nx_rs2, nx_stall, nx_flush;

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int r1, input int r2);
    logic [4:0] a, b, d;
    a = r1[4:0]; b = r2[4:0]; d = rd[4:0];
    return {7'b0, b, a, 3'b0, d, op};
  endfunction

  function automatic int fwd_of(input int rs);
    if (exmem_reg_write_i && exmem_rd_i != 0 && int'(exmem_rd_i) == rs) return 1;
    if (memwb_reg_write_i && memwb_rd_i != 0 && int'(memwb_rd_i) == rs) return 2;
    return 0;
  endfunction

  task automatic model_eval();
    logic [6:0] op;
    bit u1, u2, lu, mw;
    int r1, r2;
    op = ifid_instr_i[6:0];
    r1 = ifid_instr_i[19:15];
    r2 = ifid_instr_i[24:20];
    u1 = !(op inside {LUI, AUIPC, JAL});
    u2 = op inside {OP, STORE, BRANCH};
    lu = ifid_valid_i && idex_mem_read_i && idex_rd_i != 0 &&
         ((u1 && r1 == int'(idex_rd_i)) || (u2 && r2 == int'(idex_rd_i)));
    mw = dmem_req_i && !dmem_ready_i;
    {e_pc, e_ifid, e_ifidf, e_idex, e_idexf, e_exmem, e_memwbf, e_redir} = '0;
    if (m_halt) begin
    end else if (mw) begin
      e_memwbf = 1;
    end else if (ex_redirect_i) begin
      {e_pc, e_ifid, e_idex, e_exmem, e_ifidf, e_idexf, e_redir} = '1;
    end else if (lu) begin
      {e_idex, e_exmem, e_idexf} = '1;
    end else begin
      {e_pc, e_ifid, e_idex, e_exmem} = '1;
    end
    e_fa = fwd_of(m_rs1);
    e_fb = fwd_of(m_rs2);
    nx_rs1   = e_idexf ? 0 : (e_idex ? (u1 ? r1 : 0) : m_rs1);
    nx_rs2   = e_idexf ? 0 : (e_idex ? (u2 ? r2 : 0) : m_rs2);
    nx_stall = (!m_halt && !e_pc && m_stall < CMAX) ? m_stall + 1 : m_stall;
    nx_flush = (e_redir && m_flush < CMAX) ? m_flush + 1 : m_flush;
    nx_streak = (!m_halt && mw) ? m_streak + 1 : 0;
    nx_halt   = m_halt || (nx_streak == MEM_TIMEOUT + 1);
  endtask

  task automatic model_reset();
    m_halt = 0; m_streak = 0; m_rs1 = 0; m_rs2 = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock: compare combinational + registered outputs, then advance.
  task automatic tick();
    #1;
    model_eval();
    chk("pc_en",       pc_en_o,       e_pc);
    chk("ifid_en",     ifid_en_o,     e_ifid);
    chk("ifid_flush",  ifid_flush_o,  e_ifidf);
    chk("idex_en",     idex_en_o,     e_idex);
    chk("idex_flush",  idex_flush_o,  e_idexf);
    chk("exmem_en",    exmem_en_o,    e_exmem);
    chk("memwb_flush", memwb_flush_o, e_memwbf);
    chk("fwd_a",       fwd_a_o,       e_fa);
    chk("fwd_b",       fwd_b_o,       e_fb);
    chk("stall_cnt",   stall_cnt_o,   m_stall);
    chk("flush_cnt",   flush_cnt_o,   m_flush);
    chk("mem_err",     mem_err_o,     m_halt);
    @(posedge clk);
    m_halt = nx_halt; m_streak = nx_streak; m_rs1 = nx_rs1; m_rs2 = nx_rs2;
    m_stall = nx_stall; m_flush = nx_flush;
    #1;
  endtask

  task automatic idle();
    ifid_instr_i = mk(OPIMM, 0, 0, 0);
    ifid_valid_i = 1'b0;
    idex_rd_i = 0; idex_mem_read_i = 0;
    exmem_rd_i = 0; exmem_reg_write_i = 0;
    memwb_rd_i = 0; memwb_reg_write_i = 0;
    ex_redirect_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
  endtask

  // Reset asserted away from any clock edge; its effect must be immediate.
  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    #2;
    model_reset();
    chk("rst_mem_err",   mem_err_o,   0);
    chk("rst_stall_cnt", stall_cnt_o, 0);
    chk("rst_flush_cnt", flush_cnt_o, 0);
    chk("rst_pc_en",     pc_en_o,     1);
    chk("rst_fwd_a",     fwd_a_o,     0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  logic [6:0] ops [9] = '{LUI, AUIPC, JAL, OP, OPIMM, LOAD, STORE, BRANCH, JALR};

  initial begin
    int s0, f0;
    logic [31:0] ins;
    idle();
    rst_ni = 1'b0;
    #3;
    do_reset();
    tick();

    // load-use: lw x5 in ID/EX, add x6,x5,x7 in IF/ID
    idex_rd_i = 5; idex_mem_read_i = 1; ifid_valid_i = 1; ifid_instr_i = mk(OP, 6, 5, 7);
    #1;
    chk("lu_pc_en", pc_en_o, 0);
    chk("lu_ifid_en", ifid_en_o, 0);
    chk("lu_idex_flush", idex_flush_o, 1);
    tick();
    chk("lu_stall_cnt", stall_cnt_o, 1);
    idex_mem_read_i = 0; idex_rd_i = 0;
    #1 chk("lu_clear_pc_en", pc_en_o, 1);
    tick();

    // no false hazards
    idex_rd_i = 5; idex_mem_read_i = 1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: ifid_instr_i = mk(LUI, 5, 5, 5);
        1: ifid_instr_i = mk(JAL, 5, 5, 5);
        2: ifid_instr_i = mk(OPIMM, 6, 0, 5);
        default: begin idex_rd_i = 0; ifid_instr_i = mk(OP, 1, 0, 0); end
      endcase
      #1 chk("nofalse_pc_en", pc_en_o, 1);
      tick();
    end

    // redirect together with a load-use
    idex_rd_i = 5; idex_mem_read_i = 1; ifid_instr_i = mk(OP, 6, 5, 7); ex_redirect_i = 1;
    s0 = int'(stall_cnt_o);
    #1;
    chk("rl_ifid_flush", ifid_flush_o, 1);
    chk("rl_idex_flush", idex_flush_o, 1);
    chk("rl_pc_en", pc_en_o, 1);
    tick();
    chk("rl_flush_cnt", flush_cnt_o, 1);
    chk("rl_stall_cnt", stall_cnt_o, s0);

    // memory wait with a redirect pending
    idle(); ex_redirect_i = 1; dmem_req_i = 1;
    s0 = int'(stall_cnt_o);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_memwb_flush", memwb_flush_o, 1);
      chk("mw_exmem_en", exmem_en_o, 0);
      tick();
    end
    dmem_ready_i = 1;
    #1;
    chk("mw_release_ifid_flush", ifid_flush_o, 1);
    chk("mw_release_pc_en", pc_en_o, 1);
    tick();
    chk("mw_stall_cnt", stall_cnt_o, s0 + 3);
    chk("mw_flush_cnt", flush_cnt_o, 2);

    // forwarding: add x4,x3,x0 enters ID/EX
    idle(); ifid_valid_i = 1; ifid_instr_i = mk(OP, 4, 3, 0);
    tick();
    exmem_rd_i = 3; exmem_reg_write_i = 1; memwb_rd_i = 3; memwb_reg_write_i = 1;
    #1 chk("fwd_both", fwd_a_o, 2'b01);
    tick();
    exmem_reg_write_i = 0;
    #1 chk("fwd_wb_only", fwd_a_o, 2'b10);
    tick();
    exmem_rd_i = 0; exmem_reg_write_i = 1; memwb_rd_i = 0;
    #1 chk("fwd_x0", fwd_a_o, 2'b00);
    tick();

    // watchdog
    idle(); dmem_req_i = 1;
    s0 = int'(stall_cnt_o); f0 = int'(flush_cnt_o);
    for (int i = 0; i < 5; i++) begin
      #1 chk("wd_pre_err", mem_err_o, 0);
      tick();
    end
    #1;
    chk("wd_halt_err", mem_err_o, 1);
    chk("wd_halt_pc_en", pc_en_o, 0);
    chk("wd_stall_cnt", stall_cnt_o, s0 + 5);
    ex_redirect_i = 1; dmem_ready_i = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("wd_frozen_stall", stall_cnt_o, s0 + 5);
    chk("wd_frozen_flush", flush_cnt_o, f0);
    do_reset();
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 8)];
      ins[19:15] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      ifid_instr_i      = ins;
      ifid_valid_i      = ($urandom_range(0, 9) != 0);
      idex_rd_i         = 5'($urandom_range(0, 3));
      idex_mem_read_i   = $urandom_range(0, 1) == 1;
      exmem_rd_i        = 5'($urandom_range(0, 3));
      exmem_reg_write_i = $urandom_range(0, 1) == 1;
      memwb_rd_i        = 5'($urandom_range(0, 3));
      memwb_reg_write_i = $urandom_range(0, 1) == 1;
      ex_redirect_i     = ($urandom_range(0, 4) == 0);
      dmem_req_i        = ($urandom_range(0, 9) < 4);
      dmem_ready_i      = $urandom_range(0, 1) == 1;
      tick();
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
